// File: rtl/reg_bank_master_if.sv
// rtl/reg_bank_master_if.sv - host command/response and register-bank bus signals of the bank master
interface reg_bank_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_addr;
    logic [1:0]  cmd_len;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        en;
    logic        we;
    logic [4:0]  address;
    logic [7:0]  wdBus;
    logic [7:0]  rdBus;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, rdBus,
        output cmd_ready, rsp_valid, rsp_data, busy, en, we, address, wdBus
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, rdBus,
        input  cmd_ready, rsp_valid, rsp_data, busy, en, we, address, wdBus
    );
endinterface

// File: rtl/reg_bank_master.sv
// rtl/reg_bank_master.sv - splits one host command into 1-4 byte accesses on the 8-bit register-bank bus
module reg_bank_master #(
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    reg_bank_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [2:0] LAT3 = 3'(RD_LAT);

    state_t      state;
    state_t      state_nx;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nx;

    logic        cmd_wr_q;
    logic [4:0]  cmd_addr_q;
    logic [2:0]  cmd_n_q;
    logic [31:0] cmd_wdata_q;

    logic        en_q, we_q, rsp_valid_q;
    logic [4:0]  address_q;
    logic [7:0]  wd_q;
    logic [31:0] rsp_data_q;

    logic        en_d, we_d, rsp_valid_d;
    logic [4:0]  address_d;
    logic [7:0]  wd_d;

    logic        accept;
    logic        issue_byte;
    logic        push;

    logic        pipe_v    [RD_LAT];
    logic [1:0]  pipe_lane [RD_LAT];

    assign accept     = (state == IDLE) && bus.cmd_valid;
    // ISSUE holds one extra state cycle (cnt == N) so the registered outputs trail the state by one clock
    assign issue_byte = (state == ISSUE) && (cnt < cmd_n_q);
    assign push       = issue_byte && !cmd_wr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = ISSUE;
                    cnt_nx   = 3'd0;
                end
            end
            ISSUE: begin
                if (cnt == cmd_n_q) begin
                    state_nx = cmd_wr_q ? DONE : DRAIN;
                    cnt_nx   = cmd_wr_q ? 3'd0 : 3'd1;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            DRAIN: begin
                if (cnt == LAT3) begin
                    state_nx = DONE;
                    cnt_nx   = 3'd0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = 3'd0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 3'd0;
            end
        endcase
    end

    always_comb begin
        en_d        = 1'b0;
        we_d        = 1'b0;
        rsp_valid_d = 1'b0;
        address_d   = address_q;
        wd_d        = wd_q;
        case (state)
            ISSUE: begin
                if (issue_byte) begin
                    en_d      = 1'b1;
                    we_d      = cmd_wr_q;
                    address_d = cmd_addr_q + {2'b00, cnt};
                    if (cmd_wr_q) begin
                        wd_d = cmd_wdata_q[{cnt[1:0], 3'b000} +: 8];
                    end
                end else if (cmd_wr_q) begin
                    rsp_valid_d = 1'b1;
                end else begin
                    en_d = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == LAT3) begin
                    rsp_valid_d = 1'b1;
                end else begin
                    en_d = 1'b1;
                end
            end
            default: begin
                en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            address_q   <= 5'd0;
            wd_q        <= 8'd0;
        end else begin
            en_q        <= en_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            address_q   <= address_d;
            wd_q        <= wd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= 5'd0;
            cmd_n_q     <= 3'd1;
            cmd_wdata_q <= 32'd0;
        end else if (accept) begin
            cmd_wr_q    <= bus.cmd_write;
            cmd_addr_q  <= bus.cmd_addr;
            cmd_n_q     <= {1'b0, bus.cmd_len} + 3'd1;
            cmd_wdata_q <= bus.cmd_wdata;
        end
    end

    // Each read byte travels RD_LAT stages with its lane so it lands when the slave's data is valid
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_v[i]    <= 1'b0;
                pipe_lane[i] <= 2'd0;
            end
        end else begin
            pipe_v[0]    <= push;
            pipe_lane[0] <= cnt[1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_lane[i] <= pipe_lane[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data_q <= 32'd0;
        end else if (accept && !bus.cmd_write) begin
            rsp_data_q <= 32'd0;
        end else if (pipe_v[RD_LAT-1]) begin
            rsp_data_q[{pipe_lane[RD_LAT-1], 3'b000} +: 8] <= bus.rdBus;
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.en        = en_q;
    assign bus.we        = we_q;
    assign bus.address   = address_q;
    assign bus.wdBus     = wd_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: doc/reg_bank_master.md
Name: reg_bank_master

Overview:
- Bus initiator for the 8-bit register-bank slave interface: en, we, address[4:0], wdBus[7:0] out; rdBus[7:0] in.
- Turns one host command into 1-4 consecutive byte accesses.
  - Reads: gathers bytes into a 32-bit little-endian response.
  - Writes: scatters a 32-bit word as bytes.
- Sits between the host/CPU-side control logic and the register bank. Owns bus timing and read latency.

Parameters:
- RD_LAT, 2, cycles from the posedge that drives address to the posedge that captures rdBus (slave has a registered read port). Legal values are 1-4.

Ports:
- clk  in  1  system clock; all flops on posedge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command request
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  5  first byte address
- cmd_len  in  2  byte count minus 1 (0→1 byte … 3→4 bytes)
- cmd_wdata  in  32  write data; byte k = cmd_wdata[8k+7:8k]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  read result; byte k in [8k+7:8k]; unread bytes zero
- busy  out  1  transaction in progress (not IDLE)
- en  out  1  bus enable
- we  out  1  bus write strobe
- address  out  5  bus byte address
- wdBus  out  8  bus write data
- rdBus  in  8  bus read data from slave

Behaviour:
- Interface is decided: one clock, clk; reset is synchronous and active-high, reset.
- All outputs are registered except cmd_ready and busy, which decode from the state.
- Reset values:
  - en=0, we=0, address=0, wdBus=0.
  - rsp_valid=0, rsp_data=0.
  - State = IDLE, so cmd_ready=1 and busy=0 after reset.
- Reset mid-transaction aborts at once. The bus returns to idle at the next edge and no rsp_valid is produced.
- Command capture: accept on a posedge where cmd_valid & cmd_ready (call it T). Latch cmd_write, cmd_addr, N=cmd_len+1 and cmd_wdata. cmd_* are don't-care outside acceptance.
- States: IDLE → ISSUE → (read only) DRAIN → DONE → IDLE.
- ISSUE, lasting N cycles:
  - Byte k (k=0..N-1) drives from posedge T+1+k.
  - address = (cmd_addr+k) mod 32; wrap from 31 to 0 is silent.
  - en=1 and we=cmd_write.
  - On writes, wdBus = byte k. Outputs stay stable for the whole cycle, so a slave that samples on negedge sees settled values.
- Write path:
  - After the last byte: we=0 and en=0 at posedge T+N+1.
  - State moves to DONE; rsp_valid=1 at posedge T+N+1; rsp_data is unchanged.
- Read path:
  - Capture pipeline: a valid/lane-index shift register of depth RD_LAT.
  - Byte k is sampled from rdBus at posedge T+1+k+RD_LAT into rsp_data[8k+7:8k].
  - At command acceptance, rsp_data clears to 0.
  - DRAIN: after ISSUE, we=0 and en=1, with address held at the last byte, until the last capture.
  - rsp_valid=1 at posedge T+N+RD_LAT+1, together with en=0. Total read latency from accept to rsp_valid is N+RD_LAT+1 cycles.
- DONE lasts one cycle (rsp_valid high), then goes to IDLE.
  - cmd_ready is 0 in DONE; the earliest next accept is the edge ending the first IDLE cycle.
- rsp_data holds its value until the next read command is accepted.
- cmd_valid while busy is ignored. The host must hold it until cmd_ready.
- No write/read data forwarding: a read issued right after a write sees whatever the slave returns.

Test Plan:
- Reset, then idle for 5 cycles → en=we=0, rsp_valid=0, cmd_ready=1, rsp_data=0.
- Read addr=0, len=3, with the slave modelled so byte a returns 8'h10+a → addresses 0,1,2,3 on consecutive cycles with we=0; rsp_valid exactly 7 cycles after accept (RD_LAT=2); rsp_data=32'h13121110.
- Write addr=27, len=1, wdata=32'h0000BEEF → cycle 1: address=27, wdBus=EF, we=1; cycle 2: address=28, wdBus=BE, we=1; then en=we=0; rsp_valid 3 cycles after accept.
- Read addr=30, len=3 → addresses 30,31,0,1 (wrap); four bytes placed in lanes 0-3 in that order.
- Read len=0 at addr=22 returning 8'h5A → rsp_data=32'h0000005A; back-to-back second command with cmd_valid held → accepted the cycle after DONE; no overlap of en activity between the two.
- Reset asserted during the second ISSUE cycle of a 4-byte write → next edge en=we=0, cmd_ready=1, no rsp_valid ever for that command.
